// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard query bundle: decoded D-stage source/destination info in,
// stall / forwarding selects / HI-LO busy out.
interface hazard_scoreboard_if #(
  parameter int TNEW_W = 2
);
  logic [4:0]        d_rs;
  logic [4:0]        d_rt;
  logic [TNEW_W-1:0] d_tuse_rs;
  logic [TNEW_W-1:0] d_tuse_rt;
  logic              d_wr_en;
  logic [4:0]        d_wa;
  logic [TNEW_W-1:0] d_tnew;
  logic              d_md_start;
  logic              d_md_div;
  logic              d_hilo;
  logic              stall;
  logic [1:0]        fwd_rs;
  logic [1:0]        fwd_rt;
  logic              md_busy;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wr_en, d_wa, d_tnew,
           d_md_start, d_md_div, d_hilo,
    input  stall, fwd_rs, fwd_rt, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wr_en, d_wa, d_tnew,
           d_md_start, d_md_div, d_hilo,
    output stall, fwd_rs, fwd_rt, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based MIPS hazard unit: in-flight write slots with self-decrementing Tnew.
// HAZARD_MD_EN compiles in the multiply/divide busy counter and HI/LO interlock.
module hazard_scoreboard #(
  parameter int STAGES   = 3,
  parameter int TNEW_W   = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_scoreboard_if.slave   hz
);

  localparam int IDX_W = (STAGES > 2) ? $clog2(STAGES) : 1;

  typedef struct packed {
    logic              vld;
    logic [4:0]        wa;
    logic [TNEW_W-1:0] tnew;
  } slot_t;

  typedef struct packed {
    logic              hit;
    logic [IDX_W-1:0]  idx;
    logic [TNEW_W-1:0] tnew;
  } match_t;

  slot_t  slot_q [STAGES];
  match_t rs_m;
  match_t rt_m;
  logic   rs_stall;
  logic   rt_stall;
  logic   hilo_stall;
  logic   stall_int;
  logic   md_busy_int;

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  // Scan oldest to youngest so the lowest-index producer wins.
  function automatic match_t lookup(input logic [4:0] r);
    match_t m;
    m = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (slot_q[k].vld && slot_q[k].wa != 5'd0 && slot_q[k].wa == r) begin
        m.hit  = 1'b1;
        m.idx  = IDX_W'(k);
        m.tnew = slot_q[k].tnew;
      end
    end
    return m;
  endfunction

  // Slot 0 (E) never forwards; only a finished result in M or W does.
  function automatic logic [1:0] fwd_sel(input match_t m);
    logic [1:0] f;
    f = 2'd0;
    if (m.hit && m.tnew == '0) begin
      if (m.idx == IDX_W'(1))      f = 2'd1;
      else if (m.idx == IDX_W'(2)) f = 2'd2;
    end
    return f;
  endfunction

  always_comb begin
    rs_m = lookup(hz.d_rs);
    rt_m = lookup(hz.d_rt);
  end

  assign rs_stall  = rs_m.hit && (hz.d_tuse_rs != '1) && (hz.d_tuse_rs < rs_m.tnew);
  assign rt_stall  = rt_m.hit && (hz.d_tuse_rt != '1) && (hz.d_tuse_rt < rt_m.tnew);
  assign stall_int = rs_stall | rt_stall | hilo_stall;

  assign hz.stall   = stall_int;
  assign hz.fwd_rs  = fwd_sel(rs_m);
  assign hz.fwd_rt  = fwd_sel(rt_m);
  assign hz.md_busy = md_busy_int;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) slot_q[k] <= '0;
    end else begin
      for (int k = 1; k < STAGES; k++) begin
        slot_q[k] <= '{vld: slot_q[k-1].vld, wa: slot_q[k-1].wa,
                       tnew: sat_dec(slot_q[k-1].tnew)};
      end
      if (!stall_int)
        slot_q[0] <= '{vld: hz.d_wr_en, wa: hz.d_wa, tnew: sat_dec(hz.d_tnew)};
      else
        slot_q[0] <= '0;
    end
  end

`ifdef HAZARD_MD_EN
  localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  logic [MD_W-1:0] md_cnt;

  // A start can only be accepted with the counter idle, since HI/LO users stall on busy.
  always_ff @(posedge clk) begin
    if (reset)
      md_cnt <= '0;
    else if (hz.d_md_start && !stall_int)
      md_cnt <= hz.d_md_div ? MD_W'(DIV_LAT) : MD_W'(MULT_LAT);
    else if (md_cnt != '0)
      md_cnt <= md_cnt - MD_W'(1);
  end

  assign md_busy_int = (md_cnt != '0);
  assign hilo_stall  = hz.d_hilo && md_busy_int;
`else
  logic md_unused;
  assign md_unused   = ^{hz.d_md_start, hz.d_md_div, hz.d_hilo};
  assign md_busy_int = 1'b0;
  assign hilo_stall  = 1'b0;
`endif

endmodule
